// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Brief    : Moore-style sequencer for the multicycle CPU. It steps the shared
//            ALU, the unified memory port, the instruction register and the
//            register file through fetch/decode/execute/memory/writeback for
//            addi, lw, sw, bne and jal, with a req/ready memory handshake.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
  parameter int address_width = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [address_width-1:0] op,
  input  logic [2:0]               funct3,
  input  logic                     Zero,
  input  logic                     mem_ready,
  output logic                     mem_req,
  output logic                     AdrSrc,
  output logic                     IRWrite,
  output logic                     PCWrite,
  output logic                     MemWrite,
  output logic                     RegWrite,
  output logic [1:0]               ALUsrcA,
  output logic [1:0]               ALUsrcB,
  output logic [2:0]               ALUctrl,
  output logic [1:0]               ResultSrc,
  output logic [2:0]               ImmSrc,
  output logic                     retire,
  output logic                     illegal,
  output logic [3:0]               state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECI    = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_JAL      = 4'd9
  } state_t;

  localparam logic [6:0] c_op_lw   = 7'b0000011;
  localparam logic [6:0] c_op_sw   = 7'b0100011;
  localparam logic [6:0] c_op_addi = 7'b0010011;
  localparam logic [6:0] c_op_br   = 7'b1100011;
  localparam logic [6:0] c_op_jal  = 7'b1101111;

  state_t     state_q, state_d;
  logic [6:0] w_op;

  assign w_op    = op[6:0];
  assign state_o = state_q;

  // State register; reset returns to FETCH immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state and Moore/handshake outputs; strobes are masked while in reset.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    ALUsrcA   = 2'b00;
    ALUsrcB   = 2'b00;
    ALUctrl   = 3'b000;
    ResultSrc = 2'b00;
    ImmSrc    = 3'b000;
    retire    = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUsrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch target (or J target for jal) is precomputed into ALUOut.
        ALUsrcA = 2'b01;
        ALUsrcB = 2'b01;
        ImmSrc  = (w_op == c_op_jal) ? 3'b100 : 3'b010;
        if (w_op == c_op_lw || w_op == c_op_sw)          state_d = S_MEMADR;
        else if (w_op == c_op_addi)                      state_d = S_EXECI;
        else if (w_op == c_op_br && funct3 == 3'b001)    state_d = S_BRANCH;
        else if (w_op == c_op_jal)                       state_d = S_JAL;
        else begin
          state_d = S_FETCH;
          illegal = 1'b1;
        end
      end
      S_MEMADR: begin
        ALUsrcA = 2'b10;
        ALUsrcB = 2'b01;
        if (w_op == c_op_lw) begin
          ImmSrc  = 3'b000;
          state_d = S_MEMREAD;
        end else begin
          ImmSrc  = 3'b001;
          state_d = S_MEMWRITE;
        end
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        retire   = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECI: begin
        ALUsrcA = 2'b10;
        ALUsrcB = 2'b01;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUsrcA = 2'b10;
        ALUctrl = 3'b001;
        PCWrite = ~Zero;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        // ALUOut already holds the J target; OldPC+4 is formed for the link.
        ALUsrcA = 2'b01;
        ALUsrcB = 2'b10;
        ImmSrc  = 3'b100;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase

    if (!rst_n) begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      retire   = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_controller
// Brief    : Self-checking bench for multicycle_controller. Each instruction
//            is expanded into its expected cycle-by-cycle state list with
//            randomized wait states, and per-cycle controls plus
//            per-instruction totals are compared against that reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

  localparam int K_ADDI = 0, K_LW = 1, K_SW = 2, K_BNE = 3, K_JAL = 4, K_ILL = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       Zero;
  logic       mem_ready;
  logic       mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite;
  logic [1:0] ALUsrcA, ALUsrcB, ResultSrc;
  logic [2:0] ALUctrl, ImmSrc;
  logic       retire, illegal;
  logic [3:0] state_o;

  int total = 0;
  int bad   = 0;

  multicycle_controller #(.address_width(7)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .Zero(Zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB),
    .ALUctrl(ALUctrl), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .retire(retire), .illegal(illegal), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  // Drive opcode fields for an instruction class.
  task automatic set_op(input int kind);
    logic [6:0] ill_ops [5];
    ill_ops = '{7'b0110111, 7'b0110011, 7'b1110011, 7'b0000000, 7'b1100011};
    funct3 = 3'($urandom_range(0, 7));
    case (kind)
      K_ADDI: op = 7'b0010011;
      K_LW:   op = 7'b0000011;
      K_SW:   op = 7'b0100011;
      K_BNE:  begin op = 7'b1100011; funct3 = 3'b001; end
      K_JAL:  op = 7'b1101111;
      default: begin
        op = ill_ops[$urandom_range(0, 4)];
        if (op == 7'b1100011 && funct3 == 3'b001) funct3 = 3'b000;
      end
    endcase
  endtask

  // Runs one instruction from a FETCH cycle. wf/wd are wait cycles on the
  // fetch and data transfers; zsel is Zero during BRANCH; abort drops rst_n
  // in the first MEMWRITE cycle. Entered and left just after a rising edge.
  task automatic run_instr(input int kind, input int wf, input int wd,
                           input bit zsel, input bit abort);
    int st[$];
    bit rd[$];
    int n_ret = 0, n_ill = 0, n_rw = 0, n_mw = 0;
    set_op(kind);
    for (int i = 0; i <= wf; i++) begin st.push_back(0); rd.push_back(i == wf); end
    st.push_back(1); rd.push_back(1'b0);
    case (kind)
      K_ADDI: begin st.push_back(6); st.push_back(7); rd.push_back(0); rd.push_back(0); end
      K_LW: begin
        st.push_back(2); rd.push_back(0);
        for (int i = 0; i <= wd; i++) begin st.push_back(3); rd.push_back(i == wd); end
        st.push_back(4); rd.push_back(0);
      end
      K_SW: begin
        st.push_back(2); rd.push_back(0);
        for (int i = 0; i <= wd; i++) begin st.push_back(5); rd.push_back(i == wd); end
      end
      K_BNE: begin st.push_back(8); rd.push_back(0); end
      K_JAL: begin st.push_back(9); st.push_back(7); rd.push_back(0); rd.push_back(0); end
      default: ;
    endcase

    foreach (st[i]) begin
      int s = st[i];
      bit mem = (s == 0 || s == 3 || s == 5);
      bit r, z;
      logic [3:0] e_srca, e_srcb, e_res, e_imm;
      r = mem ? rd[i] : 1'($urandom_range(0, 1));
      z = (s == 8) ? zsel : 1'($urandom_range(0, 1));
      mem_ready = r;
      Zero      = z;
      @(negedge clk);
      e_srca = (s == 1 || s == 9) ? 4'd1 : (s == 2 || s == 6 || s == 8) ? 4'd2 : 4'd0;
      e_srcb = (s == 0 || s == 9) ? 4'd2 : (s == 1 || s == 2 || s == 6) ? 4'd1 : 4'd0;
      e_res  = (s == 0) ? 4'd2 : (s == 4) ? 4'd1 : 4'd0;
      e_imm  = (s == 1) ? ((kind == K_JAL) ? 4'd4 : 4'd2) :
               (s == 2) ? ((kind == K_SW) ? 4'd1 : 4'd0) :
               (s == 9) ? 4'd4 : 4'd0;
      chk("state",     state_o,   4'(s));
      chk("mem_req",   mem_req,   4'(mem));
      chk("AdrSrc",    AdrSrc,    4'(s == 3 || s == 5));
      chk("IRWrite",   IRWrite,   4'(s == 0 && r));
      chk("PCWrite",   PCWrite,   4'((s == 0 && r) || (s == 8 && !z) || s == 9));
      chk("MemWrite",  MemWrite,  4'(s == 5));
      chk("RegWrite",  RegWrite,  4'(s == 4 || s == 7));
      chk("ALUsrcA",   ALUsrcA,   e_srca);
      chk("ALUsrcB",   ALUsrcB,   e_srcb);
      chk("ALUctrl",   ALUctrl,   4'(s == 8));
      chk("ResultSrc", ResultSrc, e_res);
      chk("ImmSrc",    ImmSrc,    e_imm);
      chk("retire",    retire,    4'(s == 4 || s == 7 || s == 8 || (s == 5 && r)));
      chk("illegal",   illegal,   4'(s == 1 && kind == K_ILL));
      n_ret += int'(retire);
      n_ill += int'(illegal);
      n_rw  += int'(RegWrite);
      n_mw  += int'(MemWrite);
      if (abort && s == 5) begin
        #1 rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rst_state",    state_o,  4'd0);
        chk("rst_memwrite", MemWrite, 4'd0);
        chk("rst_retire",   retire,   4'd0);
        chk("rst_memreq",   mem_req,  4'd1);
        chk("rst_adrsrc",   AdrSrc,   4'd0);
        chk("rst_pcwrite",  PCWrite,  4'd0);
        @(posedge clk); #1;
        chk("rst_hold_state", state_o, 4'd0);
        chk("rst_hold_irw",   IRWrite, 4'd0);
        chk("abort_retires",  4'(n_ret), 4'd0);
        rst_n = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end

    chk("n_retire",   4'(n_ret), 4'(kind != K_ILL));
    chk("n_illegal",  4'(n_ill), 4'(kind == K_ILL));
    chk("n_regwrite", 4'(n_rw),  4'(kind == K_ADDI || kind == K_LW || kind == K_JAL));
    chk("n_memwrite", 4'(n_mw),  4'((kind == K_SW) ? wd + 1 : 0));
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    Zero      = 1'b0;
    op        = 7'b0010011;
    funct3    = 3'b000;
    #1;
    chk("reset_state",   state_o,   4'd0);
    chk("reset_memreq",  mem_req,   4'd1);
    chk("reset_irwrite", IRWrite,   4'd0);
    chk("reset_pcwrite", PCWrite,   4'd0);
    chk("reset_srcb",    ALUsrcB,   4'd2);
    chk("reset_result",  ResultSrc, 4'd2);
    @(posedge clk); #1;
    chk("reset_hold", state_o, 4'd0);
    rst_n = 1'b1;

    run_instr(K_ADDI, 0, 0, 1'b0, 1'b0);   // 0,1,6,7
    run_instr(K_LW,   0, 2, 1'b0, 1'b0);   // 0,1,2,3,3,3,4
    run_instr(K_SW,   0, 1, 1'b0, 1'b0);   // MemWrite for 2 cycles
    run_instr(K_BNE,  0, 0, 1'b0, 1'b0);   // taken
    run_instr(K_BNE,  1, 0, 1'b1, 1'b0);   // not taken
    run_instr(K_JAL,  0, 0, 1'b0, 1'b0);
    set_op(K_ILL);
    run_instr(K_ILL,  0, 0, 1'b0, 1'b0);
    run_instr(K_SW,   0, 3, 1'b0, 1'b1);   // reset during MEMWRITE
    run_instr(K_ADDI, 2, 0, 1'b0, 1'b0);   // recovers after abort

    for (int n = 0; n < 60; n++)
      run_instr($urandom_range(0, 5), $urandom_range(0, 2), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
